// File: rtl/fetch_sequencer_if.sv
// Instruction-memory and decode handshake bundle for the fetch sequencer.
// The master modport is the sequencer side; the slave side is memory plus decode.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic [15:0] imm16;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_data, instr_ready, branch, zero, imm16
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_data, instr_ready, branch, zero, imm16
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with branch-target PC update
// and a sticky acknowledge-timeout error.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | imem_req high, waiting for imem_ack
// VALID | instr holds an instruction not yet consumed by decode
// ERR   | ack timeout; frozen until reset
module fetch_sequencer #(
    parameter logic [29:0] RESET_PC    = 30'h0010_0008,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus,
    output logic [29:0]        pc,
    output logic               fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [29:0] offset;
    logic [29:0] next_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wait_cnt_d = wait_cnt_q;
        offset     = (bus.branch && bus.zero) ? {{14{bus.imm16[15]}}, bus.imm16} : 30'd0;
        next_pc    = pc_q + 30'd1 + offset;

        unique case (state_q)
            IDLE: begin
                state_d    = REQ;
                wait_cnt_d = '0;
            end
            REQ: begin
                // ack wins over the timeout when both land on the same cycle
                if (bus.imem_ack) begin
                    instr_d = bus.imem_data;
                    state_d = VALID;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            VALID: begin
                if (bus.instr_ready) begin
                    pc_d       = next_pc;
                    state_d    = REQ;
                    wait_cnt_d = '0;
                end
            end
            ERR: begin
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated with reset so nothing is offered to memory or decode while reset is asserted.
    assign bus.imem_req    = (state_q == REQ) && !reset;
    assign bus.instr_valid = (state_q == VALID) && !reset;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign pc              = pc_q;
    assign fetch_err       = (state_q == ERR);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vectors, corner sequences,
// and a randomized run against a behavioural model.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, reset_t;
    logic [29:0] pc, pc_t;
    logic        fetch_err, fetch_err_t;

    fetch_sequencer_if bus ();
    fetch_sequencer_if bus_t ();

    fetch_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .pc        (pc),
        .fetch_err (fetch_err)
    );

    fetch_sequencer #(.RESET_PC(30'h3FFF_FFFF), .ACK_TIMEOUT(4)) dut_t (
        .clk       (clk),
        .reset     (reset_t),
        .bus       (bus_t),
        .pc        (pc_t),
        .fetch_err (fetch_err_t)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.imem_ack = 0; bus.imem_data = '0; bus.instr_ready = 0;
        bus.branch = 0; bus.zero = 0; bus.imm16 = '0;
        bus_t.imem_ack = 0; bus_t.imem_data = '0; bus_t.instr_ready = 0;
        bus_t.branch = 0; bus_t.zero = 0; bus_t.imm16 = '0;
    endtask

    typedef struct {
        logic        br;
        logic        z;
        logic [15:0] imm;
        logic [31:0] data;
        logic [29:0] exp_pc;
    } vec_t;

    // Behavioural model state: phase 0 idle, 1 requesting, 2 holding instr, 3 error
    int          m_phase;
    longint      m_pc;
    logic [31:0] m_instr;
    int          m_wait;

    task automatic model_step(input logic r, input logic ack, input logic [31:0] data,
                              input logic rdy, input logic br, input logic z,
                              input logic [15:0] imm);
        longint off;
        if (r) begin
            m_phase = 0; m_pc = 64'h0010_0008; m_instr = '0; m_wait = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; m_wait = 0;
        end else if (m_phase == 1) begin
            if (ack) begin
                m_instr = data; m_phase = 2;
            end else if (m_wait == 15) begin
                m_phase = 3;
            end else begin
                m_wait++;
            end
        end else if (m_phase == 2 && rdy) begin
            off = (br && z) ? (imm[15] ? longint'(imm) - 65536 : longint'(imm)) : 0;
            m_pc = ((m_pc + 1 + off) % 1073741824 + 1073741824) % 1073741824;
            m_phase = 1; m_wait = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[8];
        logic [29:0] exp_pc;
        logic [31:0] held;
        int          n_req;

        vecs[0] = '{1'b0, 1'b0, 16'h0000, 32'h8C22_0004, 30'h0010_0009};
        vecs[1] = '{1'b1, 1'b1, 16'h0006, 32'h1111_0001, 30'h0010_0010};
        vecs[2] = '{1'b1, 1'b1, 16'hFFFC, 32'h2222_0002, 30'h0010_000D};
        vecs[3] = '{1'b1, 1'b1, 16'h0002, 32'h3333_0003, 30'h0010_0010};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFC, 32'h4444_0004, 30'h0010_0011};
        vecs[5] = '{1'b0, 1'b1, 16'h0100, 32'h5555_0005, 30'h0010_0012};
        vecs[6] = '{1'b1, 1'b1, 16'h7FFF, 32'h6666_0006, 30'h0010_8012};
        vecs[7] = '{1'b1, 1'b1, 16'h8000, 32'h7777_0007, 30'h0010_0013};

        reset = 1; reset_t = 1;
        idle_inputs();
        @(negedge clk);
        tick();
        chk("rst_req", bus.imem_req, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_pc", pc, 30'h0010_0008);
        chk("rst_instr", bus.instr, 0);
        chk("rst_err", fetch_err, 0);

        reset = 0;
        tick();
        exp_pc = 30'h0010_0008;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("vec%0d_req", i), bus.imem_req, 1);
            chk($sformatf("vec%0d_addr", i), bus.imem_addr, exp_pc);
            bus.imem_ack = 1; bus.imem_data = vecs[i].data;
            bus.branch = 1; bus.zero = 1; bus.imm16 = 16'h1234;
            tick();
            bus.imem_ack = 0;
            chk($sformatf("vec%0d_valid", i), bus.instr_valid, 1);
            chk($sformatf("vec%0d_instr", i), bus.instr, vecs[i].data);
            chk($sformatf("vec%0d_pc_hold", i), pc, exp_pc);
            bus.instr_ready = 1;
            bus.branch = vecs[i].br; bus.zero = vecs[i].z; bus.imm16 = vecs[i].imm;
            tick();
            bus.instr_ready = 0; bus.branch = 0; bus.zero = 0; bus.imm16 = '0;
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_valid_drop", i), bus.instr_valid, 0);
            exp_pc = vecs[i].exp_pc;
        end

        // delayed ack then decode stall
        n_req = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.imem_req) n_req++;
            bus.imem_ack = (k == 5);
            bus.imem_data = 32'hA5A5_0038;
            tick();
        end
        bus.imem_ack = 0;
        chk("slow_req_cycles", n_req, 6);
        chk("slow_req_drop", bus.imem_req, 0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", bus.instr_valid, 1);
            chk("stall_instr", bus.instr, 32'hA5A5_0038);
            chk("stall_pc", pc, 30'h0010_0013);
            tick();
        end
        bus.instr_ready = 1;
        tick();
        bus.instr_ready = 0;
        chk("stall_consume_pc", pc, 30'h0010_0014);

        // reset mid-request, late ack arrives while idle
        chk("midrst_req_before", bus.imem_req, 1);
        reset = 1;
        #1;
        chk("midrst_req_during", bus.imem_req, 0);
        tick();
        reset = 0; bus.imem_ack = 1; bus.imem_data = 32'hDEAD_BEEF;
        chk("midrst_req_after", bus.imem_req, 0);
        chk("midrst_valid_after", bus.instr_valid, 0);
        chk("midrst_pc", pc, 30'h0010_0008);
        tick();
        bus.imem_ack = 0;
        chk("lateack_req", bus.imem_req, 1);
        chk("lateack_valid", bus.instr_valid, 0);
        chk("lateack_instr", bus.instr, 0);
        chk("lateack_addr", bus.imem_addr, 30'h0010_0008);

        // timeout instance
        chk("t_rst_pc", pc_t, 30'h3FFF_FFFF);
        reset_t = 0;
        tick();
        n_req = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus_t.imem_req) n_req++;
            tick();
        end
        chk("to_req_cycles", n_req, 4);
        chk("to_err", fetch_err_t, 1);
        bus_t.imem_ack = 1; bus_t.imem_data = 32'h1234_5678;
        tick();
        bus_t.imem_ack = 0;
        chk("to_err_sticky", fetch_err_t, 1);
        chk("to_err_instr", bus_t.instr, 0);
        chk("to_err_valid", bus_t.instr_valid, 0);
        chk("to_err_pc", pc_t, 30'h3FFF_FFFF);

        reset_t = 1;
        tick();
        chk("to_err_cleared", fetch_err_t, 0);
        reset_t = 0;
        tick();
        n_req = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus_t.imem_req) n_req++;
            bus_t.imem_ack = (k == 3);
            bus_t.imem_data = 32'hCAFE_0001;
            tick();
        end
        bus_t.imem_ack = 0;
        chk("lastack_req_cycles", n_req, 4);
        chk("lastack_valid", bus_t.instr_valid, 1);
        chk("lastack_err", fetch_err_t, 0);
        chk("lastack_instr", bus_t.instr, 32'hCAFE_0001);
        bus_t.instr_ready = 1;
        tick();
        bus_t.instr_ready = 0;
        chk("wrap_pc", pc_t, 0);
        chk("wrap_addr", bus_t.imem_addr, 0);
        bus_t.imem_ack = 1;
        tick();
        bus_t.imem_ack = 0;
        bus_t.instr_ready = 1; bus_t.branch = 1; bus_t.zero = 1; bus_t.imm16 = 16'h8000;
        tick();
        idle_inputs();
        chk("neg_wrap_pc", pc_t, 30'h3FFF_8001);

        // randomized run against the behavioural model
        for (int i = 0; i < 2500; i++) begin
            reset = (i == 0) || ($urandom % 48 == 0);
            bus.imem_ack = ($urandom % 6 == 0);
            bus.imem_data = $urandom;
            bus.instr_ready = $urandom % 2;
            bus.branch = $urandom % 2;
            bus.zero = $urandom % 2;
            bus.imm16 = 16'($urandom);
            #1;
            if (i > 0) begin
                chk($sformatf("rnd%0d_req", i), bus.imem_req, (m_phase == 1) && !reset);
                chk($sformatf("rnd%0d_valid", i), bus.instr_valid, (m_phase == 2) && !reset);
                chk($sformatf("rnd%0d_err", i), fetch_err, m_phase == 3);
                chk($sformatf("rnd%0d_pc", i), pc, m_pc[29:0]);
                chk($sformatf("rnd%0d_addr", i), bus.imem_addr, m_pc[29:0]);
                chk($sformatf("rnd%0d_instr", i), bus.instr, m_instr);
            end
            @(posedge clk);
            model_step(reset, bus.imem_ack, bus.imem_data, bus.instr_ready,
                       bus.branch, bus.zero, bus.imm16);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 30'h0010_0008, word address loaded on reset (byte address 0x00400020).
REQ-002 Parameter ACK_TIMEOUT, default 16, maximum consecutive request cycles without acknowledge; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  30  word address of request; equals pc.
REQ-007 imem_ack  input  1  memory read done; imem_data valid this cycle.
REQ-008 imem_data  input  32  instruction word from memory.
REQ-009 instr  output  32  registered instruction handed to decode.
REQ-010 instr_valid  output  1  instr holds an unconsumed instruction.
REQ-011 instr_ready  input  1  decode consumes instr this cycle.
REQ-012 branch  input  1  consumed instruction is a conditional branch.
REQ-013 zero  input  1  ALU zero flag for consumed instruction.
REQ-014 imm16  input  16  branch word offset of consumed instruction.
REQ-015 pc  output  30  current word program counter.
REQ-016 fetch_err  output  1  sticky acknowledge-timeout error.

Function
REQ-017 FSM states SHALL be IDLE, REQ, VALID, ERR.
REQ-018 IDLE -> REQ unconditionally on next edge.
REQ-019 imem_req SHALL be 1 exactly when state == REQ; imem_addr = pc in all states.
REQ-020 REQ with imem_ack=1 -> VALID; instr <= imem_data on same edge.
REQ-021 Ack in first REQ cycle SHALL be accepted (zero-wait memory): ack in cycle n -> instr_valid=1 in cycle n+1.
REQ-022 imem_ack in IDLE, VALID or ERR SHALL be ignored; instr unchanged.
REQ-023 instr_valid SHALL be 1 exactly when state == VALID.
REQ-024 VALID with instr_ready=0: hold state, instr, pc unchanged.
REQ-025 VALID with instr_ready=1 -> REQ; pc <= next_pc on same edge.
REQ-026 next_pc = pc + 1 + sext30(imm16) if branch & zero, else pc + 1.
REQ-027 Arithmetic SHALL be 30-bit modulo 2^30; wrap past 30'h3FFF_FFFF to 0 and negative offsets below 0 wrap likewise.
REQ-028 branch, zero, imm16 SHALL be sampled only in a VALID & instr_ready cycle; ignored otherwise.
REQ-029 wait_cnt (8-bit) SHALL clear on entry to REQ and increment each REQ cycle with imem_ack=0.
REQ-030 REQ with imem_ack=0 and wait_cnt == ACK_TIMEOUT-1 -> ERR; ack in that same cycle takes priority -> VALID.
REQ-031 ERR SHALL hold imem_req=0, instr_valid=0, pc frozen, fetch_err=1 until reset.
REQ-032 pc SHALL change only on the VALID & instr_ready edge or on reset.

Reset
REQ-033 reset=1 on an edge SHALL force state=IDLE, pc=RESET_PC, instr=0, wait_cnt=0, fetch_err=0, regardless of state.
REQ-034 During and in the cycle after a reset edge: imem_req=0, instr_valid=0.
REQ-035 Reset asserted mid-request SHALL abandon the request; a late imem_ack after reset, while in IDLE, SHALL be ignored.

Verification
REQ-036 Reset, then ack in first REQ cycle with data 0x8C220004, instr_ready=1 -> imem_addr=0x00100008, instr_valid 1 cycle after ack, instr=0x8C220004, next imem_addr=0x00100009.
REQ-037 pc=0x00100010, consume with branch=1, zero=1, imm16=0xFFFC -> pc=0x0010000D; same with zero=0 -> pc=0x00100011.
REQ-038 Ack delayed 5 cycles, instr_ready held 0 for 3 cycles in VALID -> imem_req high 6 cycles, instr/pc stable while stalled, single pc increment on consume.
REQ-039 ACK_TIMEOUT=4, never ack -> imem_req high exactly 4 cycles, then fetch_err=1 sticky; ack on 4th cycle instead -> VALID, fetch_err=0.
REQ-040 pc=0x3FFFFFFF consume no-branch -> pc=0; pc=0 branch taken imm16=0x8000 -> pc=0x3FFF8001.
REQ-041 reset asserted during REQ with ack arriving next cycle -> ack ignored, state IDLE then REQ, imem_addr=RESET_PC.
